// File: rtl/display_share_arbiter.sv
// Round-robin time-slice arbiter sharing one two-digit hex display among four
// requesters; the current owner's byte is forwarded to the display driver.
module display_share_arbiter #(
    parameter int unsigned DWELL_TICKS = 50000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [31:0] val,
    output logic [7:0]  n,
    output logic        blank,
    output logic [3:0]  grant,
    output logic [1:0]  owner,
    output logic        slot_done
);

    localparam int unsigned CW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL_TICKS - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic [1:0]    ptr_r;

    logic [2:0]    pick_s;
    logic          win_s;
    logic [1:0]    win_idx_s;
    logic [7:0]    win_val_s;
    logic [7:0]    owner_val_s;
    logic          slot_end_s;

    // Returns {found, index} of the first set request at or after start (mod 4).
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Winner search and slot-end detection for the current cycle.
    always_comb begin
        pick_s      = rr_pick(req, ptr_r);
        win_s       = pick_s[2];
        win_idx_s   = pick_s[1:0];
        win_val_s   = val[{win_idx_s, 3'b000} +: 8];
        owner_val_s = val[{owner, 3'b000} +: 8];
        slot_end_s  = (req[owner] == 1'b0) || (cnt_r == LAST);
    end

    // Ownership state machine; ptr_r is owner+1 except straight after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            ptr_r     <= 2'd0;
            n         <= 8'h00;
            blank     <= 1'b1;
            grant     <= 4'b0000;
            owner     <= 2'd0;
            slot_done <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    slot_done <= 1'b0;
                    if (win_s) begin
                        state_r <= SHOW;
                        owner   <= win_idx_s;
                        grant   <= 4'b0001 << win_idx_s;
                        ptr_r   <= win_idx_s + 2'd1;
                        cnt_r   <= '0;
                        blank   <= 1'b0;
                        n       <= win_val_s;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SHOW: begin
                    if (slot_end_s) begin
                        slot_done <= 1'b1;
                        cnt_r     <= '0;
                        // Early release never finds the owner; expiry may re-grant it last.
                        if (win_s) begin
                            owner <= win_idx_s;
                            grant <= 4'b0001 << win_idx_s;
                            ptr_r <= win_idx_s + 2'd1;
                            n     <= win_val_s;
                        end else begin
                            state_r <= IDLE;
                            grant   <= 4'b0000;
                            blank   <= 1'b1;
                        end
                    end else begin
                        slot_done <= 1'b0;
                        n         <= owner_val_s;
                        cnt_r     <= cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    grant     <= 4'b0000;
                    blank     <= 1'b1;
                    slot_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_display_share_arbiter.sv
// Self-checking bench for display_share_arbiter: vector table, directed
// corner sequences, and randomized traffic against a slot-level model.
module tb_display_share_arbiter;

    localparam int DW = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic [31:0] val = 32'h0000_0000;
    logic [7:0]  n;
    logic        blank;
    logic [3:0]  grant;
    logic [1:0]  owner;
    logic        slot_done;

    int n_checks = 0;
    int n_fail   = 0;

    display_share_arbiter #(.DWELL_TICKS(DW)) dut (
        .clk(clk), .reset(reset), .req(req), .val(val),
        .n(n), .blank(blank), .grant(grant), .owner(owner), .slot_done(slot_done)
    );

    always #5 clk = ~clk;

    // Reference model: who holds the display and for how many cycles so far.
    bit         m_busy;
    int         m_owner;
    int         m_age;
    bit         m_fresh;
    logic [7:0] m_n;
    bit         m_done;

    function automatic int pick(input logic [3:0] r, input int start);
        for (int k = 0; k < 4; k++) begin
            if (r[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_age = 0; m_fresh = 1; m_n = 8'h00; m_done = 0;
    endtask

    task automatic model_edge();
        int w;
        int start;
        start  = m_fresh ? 0 : (m_owner + 1) % 4;
        m_done = 0;
        if (!m_busy) begin
            w = pick(req, start);
            if (w >= 0) begin
                m_busy = 1; m_owner = w; m_age = 1; m_n = val[8*w +: 8]; m_fresh = 0;
            end
        end else if (!req[m_owner] || m_age == DW) begin
            m_done = 1;
            w = pick(req, start);
            if (w >= 0) begin
                m_owner = w; m_age = 1; m_n = val[8*w +: 8];
            end else begin
                m_busy = 0;
            end
        end else begin
            m_age = m_age + 1;
            m_n   = val[8*m_owner +: 8];
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string p, input logic [3:0] g, input logic [1:0] o,
                           input logic [7:0] nv, input logic b, input logic d);
        chk({p, "_grant"}, 32'(grant), 32'(g));
        chk({p, "_owner"}, 32'(owner), 32'(o));
        chk({p, "_n"}, 32'(n), 32'(nv));
        chk({p, "_blank"}, 32'(blank), 32'(b));
        chk({p, "_slot_done"}, 32'(slot_done), 32'(d));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Full reset cycle; leaves time at posedge+1 with reset released.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [31:0] val;
        logic [3:0]  g;
        logic [1:0]  o;
        logic [7:0]  n;
        logic        b;
        logic        d;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(input logic [3:0] r, input logic [31:0] v, input logic [3:0] g,
                                input logic [1:0] o, input logic [7:0] nv, input logic b, input logic d);
        vec_t x;
        x.req = r; x.val = v; x.g = g; x.o = o; x.n = nv; x.b = b; x.d = d;
        return x;
    endfunction

    initial begin
        // Single requester, re-grant on expiry, release to idle, wrap search, early handover.
        tbl[0] = mk(4'b0000, 32'h0000_0000, 4'b0000, 2'd0, 8'h00, 1'b1, 1'b0);
        tbl[1] = mk(4'b0100, 32'h00A5_0000, 4'b0100, 2'd2, 8'hA5, 1'b0, 1'b0);
        for (int i = 2; i <= 8; i++) tbl[i] = mk(4'b0100, 32'h00A5_0000, 4'b0100, 2'd2, 8'hA5, 1'b0, 1'b0);
        tbl[9]  = mk(4'b0100, 32'h00A5_0000, 4'b0100, 2'd2, 8'hA5, 1'b0, 1'b1);
        tbl[10] = mk(4'b0000, 32'h00A5_0000, 4'b0000, 2'd2, 8'hA5, 1'b1, 1'b1);
        tbl[11] = mk(4'b0000, 32'h00A5_0000, 4'b0000, 2'd2, 8'hA5, 1'b1, 1'b0);
        tbl[12] = mk(4'b1001, 32'h3300_0011, 4'b1000, 2'd3, 8'h33, 1'b0, 1'b0);
        tbl[13] = mk(4'b1011, 32'h3300_0011, 4'b1000, 2'd3, 8'h33, 1'b0, 1'b0);
        tbl[14] = mk(4'b0011, 32'h3300_0011, 4'b0001, 2'd0, 8'h11, 1'b0, 1'b1);
        tbl[15] = mk(4'b0011, 32'h3300_0011, 4'b0001, 2'd0, 8'h11, 1'b0, 1'b0);

        model_reset();
        do_reset();
        chk_all("tbl_reset", 4'b0000, 2'd0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            req = tbl[i].req;
            val = tbl[i].val;
            step();
            chk_all($sformatf("tbl%0d", i), tbl[i].g, tbl[i].o, tbl[i].n, tbl[i].b, tbl[i].d);
        end

        // Full contention: owners 0,1,2,3,0 for exactly DW cycles each.
        req = 4'b1111;
        val = 32'h3322_1100;
        do_reset();
        for (int s = 0; s < 5; s++) begin
            for (int c = 0; c < DW; c++) begin
                step();
                chk($sformatf("cont_grant_s%0d_c%0d", s, c), 32'(grant), 32'(1) << (s % 4));
                chk($sformatf("cont_n_s%0d_c%0d", s, c), 32'(n), 32'((s % 4) * 8'h11));
                chk($sformatf("cont_done_s%0d_c%0d", s, c), 32'(slot_done), 32'((c == 0 && s > 0) ? 1 : 0));
            end
        end

        // Asynchronous reset mid-slot, then 20 idle cycles.
        step();
        reset = 1'b1;
        #1;
        model_reset();
        chk_all("async_reset", 4'b0000, 2'd0, 8'h00, 1'b1, 1'b0);
        req = 4'b0000;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            chk_all($sformatf("idle%0d", c), 4'b0000, 2'd0, 8'h00, 1'b1, 1'b0);
        end

        // Early release: owner 1 drops in cycle 3, owner 3 then gets a full slot.
        val = 32'h3C00_2200;
        req = 4'b0010;
        do_reset();
        for (int c = 0; c < 3; c++) step();
        chk_all("er_owner1", 4'b0010, 2'd1, 8'h22, 1'b0, 1'b0);
        req = 4'b1000;
        step();
        chk_all("er_handover", 4'b1000, 2'd3, 8'h3C, 1'b0, 1'b1);
        for (int c = 1; c < DW; c++) begin
            step();
            chk_all($sformatf("er_hold%0d", c), 4'b1000, 2'd3, 8'h3C, 1'b0, 1'b0);
        end
        step();
        chk_all("er_regrant", 4'b1000, 2'd3, 8'h3C, 1'b0, 1'b1);

        // Live value tracking, no preemption, then wrap search at expiry.
        val = 32'h1000_005A;
        req = 4'b1000;
        do_reset();
        step();
        chk_all("lv_grant", 4'b1000, 2'd3, 8'h10, 1'b0, 1'b0);
        step();
        step();
        val = 32'h7F00_005A;
        req = 4'b1001;
        step();
        chk_all("lv_track", 4'b1000, 2'd3, 8'h7F, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("lv_nopreempt%0d", c), 32'(grant), 32'(4'b1000));
        end
        step();
        chk_all("lv_wrap", 4'b0001, 2'd0, 8'h5A, 1'b0, 1'b1);

        // Sole owner releases: back to idle, owner and n hold, single pulse.
        val = 32'h0000_4400;
        req = 4'b0010;
        do_reset();
        step();
        step();
        req = 4'b0000;
        val = 32'h0000_9900;
        step();
        chk_all("rel_idle", 4'b0000, 2'd1, 8'h44, 1'b1, 1'b1);
        step();
        chk_all("rel_hold", 4'b0000, 2'd1, 8'h44, 1'b1, 1'b0);

        // Randomized traffic against the model, with occasional async resets.
        req = 4'b0000;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) req = req ^ 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) val = $urandom;
            if ($urandom_range(0, 399) == 0) begin
                reset = 1'b1;
                #1;
                model_reset();
                chk_all("rand_reset", 4'b0000, 2'd0, 8'h00, 1'b1, 1'b0);
                #1;
                reset = 1'b0;
            end
            step();
            chk_all("rand", m_busy ? 4'(4'b0001 << m_owner) : 4'b0000, 2'(m_owner), m_n, !m_busy, m_done);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/display_share_arbiter.md
# display_share_arbiter

Round-robin time-slice arbiter that shares the single two-digit hex display (driven through `display_7_seg_hex`) between four requesters. Each requester raises a request and supplies an 8-bit value. The arbiter grants the display to one requester at a time for a fixed dwell period, then forwards the owner's value to the display driver's `n` input. It sits between application logic (counters, UART status, switches) and the display multiplexer.

## Interface
Parameters:
- `DWELL_TICKS`, default 50000000: clock cycles per display slot (1 s at 50 MHz). Legal range ≥ 2. Counter width is $clog2(DWELL_TICKS).

Ports:
- `clk` input 1: system clock. All state changes on its rising edge.
- `reset` input 1: reset, asynchronous and active-high.
- `req` input 4: request level per requester; bit i belongs to requester i.
- `val` input 32: requester values; `val[8i+7:8i]` belongs to requester i.
- `n` output 8: value to the display driver; registered.
- `blank` output 1: 1 when no owner; the display should be dark or ignored.
- `grant` output 4: one-hot owner; all zero when idle.
- `owner` output 2: binary index of the owner; holds the last owner while idle.
- `slot_done` output 1: one-cycle pulse when a slot ends.

## Operation
- Reset values: `n`=0, `blank`=1, `grant`=0, `owner`=0, `slot_done`=0, dwell counter=0, round-robin pointer=0, state=IDLE.
- States: IDLE and SHOW.
- **Round-robin search:** starts at index `owner+1` (mod 4), or at 0 straight after reset, and picks the first index with `req` set.
- **IDLE:**
  - If `req`≠0, go to SHOW.
  - Load `owner` and `grant` from the round-robin search.
  - Clear the dwell counter and set `blank`=0.
- **SHOW, each cycle:**
  - `n` ← `val` slice of the current owner (live tracking; the value may change mid-slot).
  - The dwell counter increments.
- **Early release:** if `req[owner]`=0 in SHOW, the slot ends this cycle and `slot_done` pulses.
  - If any other req is set, grant passes to the round-robin winner with the counter cleared.
  - Otherwise, go to IDLE: `grant`=0, `blank`=1, and `n` holds its last value.
- **Expiry:** when counter = DWELL_TICKS-1, the slot ends and `slot_done` pulses.
  - The search excludes no one but starts at `owner+1`, so other requesters win before the current owner.
  - If only the owner requests, it is re-granted with the counter cleared (`grant` stays asserted, no gap).
  - If nobody requests, go to IDLE.
- **Simultaneous early release and expiry:** treated as a single slot end with one `slot_done` pulse.
- **Ownership timing:** grant changes occur only at slot end; a new request never preempts a running slot.
- **Counter:** the counter never wraps past DWELL_TICKS-1.
- **Reset mid-slot:** all outputs return to reset values immediately (async). The pointer restarts at 0.

## Timing
- Request to grant latency from IDLE: `req` high at edge k gives `grant`, `owner`, `blank`=0 and `n`=val after edge k+1 (1 cycle).
- Value tracking latency in SHOW: 1 cycle from `val` change to `n`.
- Slot length under continuous contention: exactly DWELL_TICKS cycles per owner.
- Handover: `slot_done` is high in the same cycle the new `grant` first appears, with no blank cycle between owners.
- Early release: `req[owner]` falling at edge k gives a handover or IDLE after edge k+1.
- `grant` is always one-hot or zero, and `owner` matches `grant` whenever `grant`≠0.

## Test plan
All scenarios use DWELL_TICKS=8.
1. **Reset and idle:** assert `reset` mid-slot, then release with `req`=0 → `blank`=1, `grant`=0, `n`=0, `slot_done`=0 immediately and for 20 cycles.
2. **Single requester:**
   - Stimulus: `req`=4'b0100 with `val[23:16]`=8'hA5 held.
   - Response: one cycle later `grant`=4'b0100, `owner`=2, `n`=8'hA5, `blank`=0.
   - Response: `slot_done` pulses every 8 cycles and `grant` never drops.
3. **Full contention:**
   - Stimulus: `req`=4'b1111 from reset, with `val` slices 8'h00, 8'h11, 8'h22, 8'h33.
   - Response: owners 0,1,2,3,0 in order, 8 cycles each.
   - Response: `n` steps through 00,11,22,33 and `slot_done` pulses at each boundary.
4. **Early release:** owner 1 drops `req` at cycle 3 of its slot while `req[3]`=1 → `slot_done` pulses and `grant`=4'b1000 on the next cycle; owner 3 then gets a full 8-cycle slot.
5. **Live value and wrap search:**
   - Stimulus 1: during owner 3's slot, change `val[31:24]` from 8'h10 to 8'h7F.
   - Response 1: `n`=8'h7F one cycle later.
   - Stimulus 2: at expiry, `req`=4'b1001.
   - Response 2: the next owner is 0, not 3.
6. **Release to idle:** the sole owner drops `req` → `blank`=1, `grant`=0, `owner` and `n` hold their values, and a single `slot_done` pulse is seen.
